// File: rtl/card_grid_renderer_if.sv
// Raster-in / ROM-bus / pixel-out bundle for card_grid_renderer.
// master = renderer, slave = raster source, card ROM and display mixer.
interface card_grid_renderer_if #(
   parameter int unsigned TYPE_W = 6
) ();
   logic              pix_en;
   logic [9:0]        h_cnt;
   logic [9:0]        v_cnt;
   logic [TYPE_W-1:0] rom_type;
   logic [5:0]        rom_x;
   logic [5:0]        rom_y;
   logic [11:0]       rom_pixel;
   logic [11:0]       card_pixel;
   logic              card_valid;

   modport master (
      input  pix_en, h_cnt, v_cnt, rom_pixel,
      output rom_type, rom_x, rom_y, card_pixel, card_valid
   );

   modport slave (
      output pix_en, h_cnt, v_cnt, rom_pixel,
      input  rom_type, rom_x, rom_y, card_pixel, card_valid
   );
endinterface

// File: rtl/card_grid_renderer.sv
// 3-stage card-grid pixel generator: slot decode + ROM address, ROM wait, frame overlay.
// Optional selection-frame blinking is enabled by defining CARD_FRAME_BLINK_EN.
module card_grid_renderer #(
   parameter int unsigned COLS        = 18,
   parameter int unsigned ROWS        = 8,
   parameter int unsigned SPLIT_ROW   = 6,
   parameter int unsigned TYPE_W      = 6,
   parameter int unsigned X0          = 32,
   parameter int unsigned Y0          = 19,
   parameter int unsigned Y1          = 360,
   parameter int unsigned PITCH_X     = 32,
   parameter int unsigned PITCH_Y     = 55,
   parameter int unsigned CARD_W      = 32,
   parameter int unsigned CARD_H      = 46,
   parameter int unsigned FRAME_W     = 2,
   parameter logic [11:0] FRAME_COLOR = 12'hFD3
`ifdef CARD_FRAME_BLINK_EN
   , parameter int unsigned BLINK_FRAMES = 30
`endif
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ROWS*COLS*TYPE_W-1:0]   map,
   input  logic [ROWS*COLS-1:0]          sel_card,
   card_grid_renderer_if.master          bus
);

   localparam int unsigned NSLOT = ROWS * COLS;
   localparam int unsigned SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

   logic [TYPE_W-1:0] map_arr [NSLOT];
   for (genvar p = 0; p < NSLOT; p++) begin : g_map
      assign map_arr[p] = map[p*TYPE_W +: TYPE_W];
   end

   int unsigned       hv, vv, hx, vy, col, row, lx, ly;
   logic              in_h, in_board, in_hand, in_slot;
   logic [SW-1:0]     slot_idx;
   logic [TYPE_W-1:0] ctype;
   logic              in_card_c, frame_c, frame_draw;

   always_comb begin
      hv       = 32'(bus.h_cnt);
      vv       = 32'(bus.v_cnt);
      in_h     = (hv >= X0) && (hv < X0 + COLS * PITCH_X);
      in_board = (vv >= Y0) && (vv < Y0 + SPLIT_ROW * PITCH_Y);
      in_hand  = (vv >= Y1) && (vv < Y1 + (ROWS - SPLIT_ROW) * PITCH_Y);
      // Offsets wrap when out of range; in_slot masks them before use.
      hx       = hv - X0;
      vy       = in_board ? (vv - Y0) : (vv - Y1);
      col      = hx / PITCH_X;
      lx       = hx - col * PITCH_X;
      row      = (vy / PITCH_Y) + (in_board ? 0 : SPLIT_ROW);
      ly       = vy - (vy / PITCH_Y) * PITCH_Y;
      in_slot  = in_h && (in_board || in_hand);
      slot_idx = in_slot ? SW'(row * COLS + col) : '0;
      ctype    = map_arr[slot_idx];
      in_card_c = in_slot && (lx < CARD_W) && (ly < CARD_H) && (ctype != '0);
      frame_c   = sel_card[slot_idx] &&
                  ((lx < FRAME_W) || (lx >= CARD_W - FRAME_W) ||
                   (ly < FRAME_W) || (ly >= CARD_H - FRAME_W));
   end

`ifdef CARD_FRAME_BLINK_EN
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BW-1:0] frame_cnt_q;
   logic          blink_on_q;

   // One count per video frame, taken at the raster origin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (bus.pix_en && (bus.h_cnt == '0) && (bus.v_cnt == '0)) begin
         if (frame_cnt_q == BW'(BLINK_FRAMES - 1)) begin
            frame_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
         end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
      end
   end

   assign frame_draw = frame_c & blink_on_q;
`else
   assign frame_draw = frame_c;
`endif

   logic [TYPE_W-1:0] rom_type_q;
   logic [5:0]        rom_x_q, rom_y_q;
   logic              in_card_q1, frame_q1, in_card_q2, frame_q2;
   logic [11:0]       card_pixel_q;
   logic              card_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_type_q   <= '0;
         rom_x_q      <= '0;
         rom_y_q      <= '0;
         in_card_q1   <= 1'b0;
         frame_q1     <= 1'b0;
         in_card_q2   <= 1'b0;
         frame_q2     <= 1'b0;
         card_pixel_q <= '0;
         card_valid_q <= 1'b0;
      end else if (bus.pix_en) begin
         rom_type_q   <= in_card_c ? ctype : '0;
         rom_x_q      <= in_card_c ? 6'(lx) : '0;
         rom_y_q      <= in_card_c ? 6'(ly) : '0;
         in_card_q1   <= in_card_c;
         frame_q1     <= in_card_c & frame_draw;
         // ROM data for the S1 address lands with this stage.
         in_card_q2   <= in_card_q1;
         frame_q2     <= frame_q1;
         card_valid_q <= in_card_q2;
         card_pixel_q <= !in_card_q2 ? 12'h000 : (frame_q2 ? FRAME_COLOR : bus.rom_pixel);
      end
   end

   assign bus.rom_type   = rom_type_q;
   assign bus.rom_x      = rom_x_q;
   assign bus.rom_y      = rom_y_q;
   assign bus.card_pixel = card_pixel_q;
   assign bus.card_valid = card_valid_q;

endmodule

// File: tb/tb_card_grid_renderer.sv
// Bench for card_grid_renderer: slot-rectangle reference model, synchronous ROM model,
// per-cycle comparison plus directed literal checks.
module tb_card_grid_renderer;

   localparam int COLS = 18, ROWS = 8, SPLIT_ROW = 6, TYPE_W = 6;
   localparam int X0 = 32, Y0 = 19, Y1 = 360, PITCH_X = 32, PITCH_Y = 55;
   localparam int CARD_W = 32, CARD_H = 46, FRAME_W = 2;
   localparam logic [11:0] FRAME_COLOR = 12'hFD3;
   localparam int NSLOT = ROWS * COLS;
   localparam int MAP_W = NSLOT * TYPE_W;

   typedef struct packed {
      logic        valid;
      logic [11:0] pix;
      logic [5:0]  t;
      logic [5:0]  x;
      logic [5:0]  y;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [MAP_W-1:0] map;
   logic [NSLOT-1:0] sel_card;
   logic             run_cmp = 1'b0;
   int               checks = 0;
   int               errors = 0;

   card_grid_renderer_if #(.TYPE_W(TYPE_W)) bus ();

   card_grid_renderer dut (
      .clk      (clk),
      .rst      (rst),
      .map      (map),
      .sel_card (sel_card),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_fn(logic [5:0] t, logic [5:0] x, logic [5:0] y);
      return 12'(int'(t) * 97 + int'(x) * 33 + int'(y) * 5 + 1);
   endfunction

   // Card rectangles are tested slot by slot; no division involved.
   function automatic exp_t model(int h, int v, logic [MAP_W-1:0] m, logic [NSLOT-1:0] s);
      exp_t e;
      e = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            int left, top, p, x, y;
            logic [5:0] t;
            logic fr;
            left = X0 + c * PITCH_X;
            top  = (r < SPLIT_ROW) ? Y0 + r * PITCH_Y : Y1 + (r - SPLIT_ROW) * PITCH_Y;
            p    = r * COLS + c;
            if (h >= left && h < left + CARD_W && v >= top && v < top + CARD_H) begin
               t = m[p*TYPE_W +: TYPE_W];
               if (t != 0) begin
                  x  = h - left;
                  y  = v - top;
                  fr = s[p] && (x < FRAME_W || x >= CARD_W - FRAME_W ||
                                y < FRAME_W || y >= CARD_H - FRAME_W);
                  e.valid = 1'b1;
                  e.t     = t;
                  e.x     = 6'(x);
                  e.y     = 6'(y);
                  e.pix   = fr ? FRAME_COLOR : rom_fn(t, 6'(x), 6'(y));
               end
            end
         end
      end
      return e;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous card ROM: data follows the address one strobe later.
   always @(posedge clk) begin
      if (bus.pix_en) bus.rom_pixel <= rom_fn(bus.rom_type, bus.rom_x, bus.rom_y);
   end

   // e0: latest sampled position, e2: the one now due on card_pixel.
   exp_t e0, e1, e2;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e0 <= '0;
         e1 <= '0;
         e2 <= '0;
      end else if (bus.pix_en) begin
         e0 <= model(int'(bus.h_cnt), int'(bus.v_cnt), map, sel_card);
         e1 <= e0;
         e2 <= e1;
      end
   end

   always @(negedge clk) begin
      if (run_cmp && !rst) begin
         chk("cmp_rom_type",   int'(bus.rom_type),   int'(e0.t));
         chk("cmp_rom_x",      int'(bus.rom_x),      int'(e0.x));
         chk("cmp_rom_y",      int'(bus.rom_y),      int'(e0.y));
         chk("cmp_card_valid", int'(bus.card_valid), int'(e2.valid));
         chk("cmp_card_pixel", int'(bus.card_pixel), int'(e2.pix));
      end
   end

   task automatic go(int h, int v, int n);
      bus.h_cnt  = 10'(h);
      bus.v_cnt  = 10'(v);
      bus.pix_en = 1'b1;
      repeat (n) @(posedge clk);
      #2;
   endtask

   // One strobe at (h, v), then three idle cycles at the origin.
   task automatic pulse(int h, int v);
      bus.h_cnt  = 10'(h);
      bus.v_cnt  = 10'(v);
      bus.pix_en = 1'b1;
      @(posedge clk);
      #2;
      bus.pix_en = 1'b0;
      bus.h_cnt  = '0;
      bus.v_cnt  = '0;
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic set_type(int p, int t);
      map[p*TYPE_W +: TYPE_W] = 6'(t);
   endtask

   initial begin
      rst        = 1'b1;
      map        = '0;
      sel_card   = '0;
      bus.pix_en = 1'b0;
      bus.h_cnt  = '0;
      bus.v_cnt  = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_rom_type",   int'(bus.rom_type),   0);
      chk("rst_card_valid", int'(bus.card_valid), 0);
      chk("rst_card_pixel", int'(bus.card_pixel), 0);
      rst     = 1'b0;
      run_cmp = 1'b1;

      // First card pixel, 2-strobe latency
      set_type(0, 5);
      go(32, 19, 1);
      chk("s1_rom_type", int'(bus.rom_type), 5);
      chk("s1_rom_x", int'(bus.rom_x), 0);
      chk("s1_rom_y", int'(bus.rom_y), 0);
      chk("s1_valid_early", int'(bus.card_valid), 0);
      go(32, 19, 1);
      chk("s2_valid_early", int'(bus.card_valid), 0);
      go(32, 19, 1);
      chk("s3_valid", int'(bus.card_valid), 1);
      chk("s3_pixel", int'(bus.card_pixel), 12'h1E6);

      sel_card[0] = 1'b1;
      go(63, 64, 3);
      chk("frame_br_rom_x", int'(bus.rom_x), 31);
      chk("frame_br_rom_y", int'(bus.rom_y), 45);
      chk("frame_br_pixel", int'(bus.card_pixel), int'(FRAME_COLOR));
      go(33, 40, 3);
      chk("frame_left_pixel", int'(bus.card_pixel), int'(FRAME_COLOR));
      go(40, 30, 3);
      chk("interior_pixel", int'(bus.card_pixel), 12'h325);
      go(40, 70, 3);
      chk("gap_valid", int'(bus.card_valid), 0);
      chk("gap_pixel", int'(bus.card_pixel), 0);
      chk("gap_rom_type", int'(bus.rom_type), 0);

      sel_card[0] = 1'b0;
      set_type(108, 9);
      go(32, 360, 3);
      chk("hand_rom_type", int'(bus.rom_type), 9);
      chk("hand_pixel", int'(bus.card_pixel), 12'h36A);
      go(32, 355, 3);
      chk("between_valid", int'(bus.card_valid), 0);
      go(70, 25, 3);
      chk("empty_valid", int'(bus.card_valid), 0);
      chk("empty_pixel", int'(bus.card_pixel), 0);
      chk("empty_rom_type", int'(bus.rom_type), 0);

      // Freeze with pix_en low
      go(40, 30, 3);
      bus.pix_en = 1'b0;
      bus.h_cnt  = '0;
      bus.v_cnt  = '0;
      repeat (5) @(posedge clk);
      #2;
      chk("freeze_valid", int'(bus.card_valid), 1);
      chk("freeze_pixel", int'(bus.card_pixel), 12'h325);
      chk("freeze_rom_type", int'(bus.rom_type), 5);

      // Sparse strobes: latency counted in strobes, not clocks
      for (int i = 0; i < 3; i++) pulse(0, 0);
      pulse(40, 30);
      chk("sparse_k0_valid", int'(bus.card_valid), 0);
      pulse(0, 0);
      chk("sparse_k1_valid", int'(bus.card_valid), 0);
      pulse(0, 0);
      chk("sparse_k2_valid", int'(bus.card_valid), 1);
      chk("sparse_k2_pixel", int'(bus.card_pixel), 12'h325);
      pulse(0, 0);
      chk("sparse_k3_valid", int'(bus.card_valid), 0);

      // Asynchronous reset mid-line
      go(40, 30, 3);
      chk("pre_rst_valid", int'(bus.card_valid), 1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", int'(bus.card_valid), 0);
      chk("async_rst_pixel", int'(bus.card_pixel), 0);
      chk("async_rst_rom_type", int'(bus.rom_type), 0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Sweep the bottom frame band across slots 0..2
      sel_card[1] = 1'b1;
      set_type(1, 3);
      for (int h = 20; h < 140; h++) go(h, 63, 1);

      // Random map, selection, raster and strobe pattern
      for (int p = 0; p < NSLOT; p++) set_type(p, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63));
      for (int p = 0; p < NSLOT; p++) sel_card[p] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 600; i++) begin
         bus.h_cnt  = 10'($urandom_range(0, 639));
         bus.v_cnt  = 10'($urandom_range(0, 479));
         bus.pix_en = 1'($urandom_range(0, 1));
         if (i % 97 == 0) set_type($urandom_range(0, NSLOT - 1), $urandom_range(0, 63));
         @(posedge clk);
         #2;
      end

      bus.pix_en = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
